// File: rtl/s5851a_i2c_slv.sv
// s5851a_i2c_slv: I2C target model of the S5851A temperature sensor.
// Address / pointer / data protocol over open-drain SCL/SDA, CONFIG/TLOW/THIGH
// registers, snapshotted temperature reads and a hysteretic ALERT flag.
// Optional build macro S5851A_I2C_SLV_GLITCH_FILT_EN inserts a C_FILT_LEN-cycle
// stability filter on both synchronised bus lines.
module s5851a_i2c_slv #(
    parameter logic [6:0]  C_SLV_ADR   = 7'h48,
    parameter logic [15:0] C_TLOW_INI  = 16'h4B00,
    parameter logic [15:0] C_THIGH_INI = 16'h5000,
    parameter int          C_FILT_LEN  = 3
) (
    input  logic        CK_i,
    input  logic        SRST_i,
    input  logic        SCLI_i,
    input  logic        SDAI_i,
    output logic        SDAO_o,
    input  logic [11:0] TEMPs_i,
    output logic [7:0]  CONFIGs_o,
    output logic [15:0] TLOWs_o,
    output logic [15:0] THIGHs_o,
    output logic        ALERT_o,
    output logic        BUSY_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_ADR, S_ADR_ACK, S_WT_DAT, S_WT_ACK, S_RD_DAT, S_RD_ACK, S_IGNORE
    } state_t;

    // bit 0 = SCL, bit 1 = SDA throughout the line path
    logic [1:0] meta_q, sync_q, line_s, line_d_q;

    // Two-flop synchroniser plus one delay stage for edge detection
    always_ff @(posedge CK_i) begin
        if (SRST_i) begin
            meta_q   <= 2'b11;
            sync_q   <= 2'b11;
            line_d_q <= 2'b11;
        end else begin
            meta_q   <= {SDAI_i, SCLI_i};
            sync_q   <= meta_q;
            line_d_q <= line_s;
        end
    end

`ifdef S5851A_I2C_SLV_GLITCH_FILT_EN
    localparam int CW = $clog2(C_FILT_LEN + 1);
    logic [1:0]         filt_q, filt_d;
    logic [1:0][CW-1:0] fcnt_q, fcnt_d;

    // Output follows a line only after C_FILT_LEN consecutive differing samples
    always_comb begin
        filt_d = filt_q;
        fcnt_d = fcnt_q;
        for (int i = 0; i < 2; i++) begin
            if (sync_q[i] == filt_q[i]) begin
                fcnt_d[i] = '0;
            end else if (fcnt_q[i] == CW'(C_FILT_LEN - 1)) begin
                filt_d[i] = sync_q[i];
                fcnt_d[i] = '0;
            end else begin
                fcnt_d[i] = fcnt_q[i] + CW'(1);
            end
        end
    end

    // Filter state register
    always_ff @(posedge CK_i) begin
        if (SRST_i) begin
            filt_q <= 2'b11;
            fcnt_q <= '0;
        end else begin
            filt_q <= filt_d;
            fcnt_q <= fcnt_d;
        end
    end

    assign line_s = filt_q;
`else
    assign line_s = sync_q;
`endif

    logic scl_rise, scl_fall, start_det, stop_det, sda;

    assign sda       = line_s[1];
    assign scl_rise  =  line_s[0] & ~line_d_q[0];
    assign scl_fall  = ~line_s[0] &  line_d_q[0];
    assign start_det =  line_s[0] &  line_d_q[0] & ~line_s[1] &  line_d_q[1];
    assign stop_det  =  line_s[0] &  line_d_q[0] &  line_s[1] & ~line_d_q[1];

    state_t      state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [1:0]  idx_q, idx_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [7:0]  sh_q, sh_d;
    logic        rw_q, rw_d;
    logic [7:0]  msb_q, msb_d;
    logic [7:0]  cfg_q, cfg_d;
    logic [15:0] tlow_q, tlow_d;
    logic [15:0] thigh_q, thigh_d;
    logic [11:0] snap_q, snap_d;
    logic        sdao_q, sdao_d;
    logic        alert_q, alert_d;

    logic [7:0]  rx_byte;
    logic [15:0] rd_word;
    logic [7:0]  rd_byte;

    assign rx_byte = {sh_q[6:0], sda};

    // Read mux: P1 repeats CONFIG for every byte, others give MSB, LSB, then FF
    always_comb begin
        rd_word = {cfg_q, cfg_q};
        case (ptr_q)
            2'd0:    rd_word = {snap_q, 4'h0};
            2'd1:    rd_word = {cfg_q, cfg_q};
            2'd2:    rd_word = tlow_q;
            default: rd_word = thigh_q;
        endcase
        case (idx_q)
            2'd0:    rd_byte = rd_word[15:8];
            2'd1:    rd_byte = rd_word[7:0];
            default: rd_byte = (ptr_q == 2'd1) ? cfg_q : 8'hFF;
        endcase
    end

    // Protocol FSM: bits sampled on SCL rise, SDA drive changed on SCL fall
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        idx_d     = idx_q;
        ptr_d     = ptr_q;
        sh_d      = sh_q;
        rw_d      = rw_q;
        msb_d     = msb_q;
        cfg_d     = cfg_q;
        tlow_d    = tlow_q;
        thigh_d   = thigh_q;
        snap_d    = snap_q;
        sdao_d    = sdao_q;

        if (start_det) begin
            state_d   = S_ADR;
            bit_cnt_d = '0;
            idx_d     = '0;
            sdao_d    = 1'b1;
        end else if (stop_det) begin
            state_d = S_IDLE;
            sdao_d  = 1'b1;
        end else begin
            case (state_q)
                S_ADR: begin
                    if (scl_rise) begin
                        sh_d      = rx_byte;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (rx_byte[7:1] == C_SLV_ADR) begin
                                state_d = S_ADR_ACK;
                                rw_d    = rx_byte[0];
                                // coherent MSB/LSB: freeze temperature for this read
                                if (rx_byte[0]) snap_d = TEMPs_i;
                            end else begin
                                state_d = S_IGNORE;
                            end
                        end
                    end
                end
                S_ADR_ACK: begin
                    if (scl_fall) sdao_d = 1'b0;
                    if (scl_rise) begin
                        state_d   = rw_q ? S_RD_DAT : S_WT_DAT;
                        bit_cnt_d = '0;
                    end
                end
                S_WT_DAT: begin
                    if (scl_fall) sdao_d = 1'b1;
                    if (scl_rise) begin
                        sh_d      = rx_byte;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d = S_WT_ACK;
                            idx_d   = (idx_q == 2'd3) ? 2'd3 : idx_q + 2'd1;
                            if (idx_q == 2'd0) begin
                                ptr_d = rx_byte[1:0];
                            end else begin
                                case (ptr_q)
                                    2'd1: cfg_d = rx_byte;
                                    2'd2: begin
                                        if (idx_q == 2'd1) msb_d  = rx_byte;
                                        if (idx_q == 2'd2) tlow_d = {msb_q, rx_byte};
                                    end
                                    2'd3: begin
                                        if (idx_q == 2'd1) msb_d   = rx_byte;
                                        if (idx_q == 2'd2) thigh_d = {msb_q, rx_byte};
                                    end
                                    default: ;
                                endcase
                            end
                        end
                    end
                end
                S_WT_ACK: begin
                    if (scl_fall) sdao_d = 1'b0;
                    if (scl_rise) begin
                        state_d   = S_WT_DAT;
                        bit_cnt_d = '0;
                    end
                end
                S_RD_DAT: begin
                    if (scl_fall) sdao_d = rd_byte[3'd7 - bit_cnt_q];
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) state_d = S_RD_ACK;
                    end
                end
                S_RD_ACK: begin
                    if (scl_fall) sdao_d = 1'b1;
                    if (scl_rise) begin
                        bit_cnt_d = '0;
                        if (!sda) begin
                            state_d = S_RD_DAT;
                            idx_d   = (idx_q == 2'd3) ? 2'd3 : idx_q + 2'd1;
                        end else begin
                            state_d = S_IGNORE;
                        end
                    end
                end
                S_IGNORE: sdao_d = 1'b1;
                default:  sdao_d = 1'b1;
            endcase
        end
    end

    // Hysteretic over-temperature flag on signed 12-bit values
    always_comb begin
        alert_d = alert_q;
        if ($signed(TEMPs_i) > $signed(thigh_q[15:4]))
            alert_d = 1'b1;
        else if ($signed(TEMPs_i) < $signed(tlow_q[15:4]))
            alert_d = 1'b0;
    end

    // State and register file
    always_ff @(posedge CK_i) begin
        if (SRST_i) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
            idx_q     <= '0;
            ptr_q     <= '0;
            sh_q      <= '0;
            rw_q      <= 1'b0;
            msb_q     <= '0;
            cfg_q     <= '0;
            tlow_q    <= C_TLOW_INI;
            thigh_q   <= C_THIGH_INI;
            snap_q    <= '0;
            sdao_q    <= 1'b1;
            alert_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            idx_q     <= idx_d;
            ptr_q     <= ptr_d;
            sh_q      <= sh_d;
            rw_q      <= rw_d;
            msb_q     <= msb_d;
            cfg_q     <= cfg_d;
            tlow_q    <= tlow_d;
            thigh_q   <= thigh_d;
            snap_q    <= snap_d;
            sdao_q    <= sdao_d;
            alert_q   <= alert_d;
        end
    end

    assign SDAO_o    = sdao_q;
    assign CONFIGs_o = cfg_q;
    assign TLOWs_o   = tlow_q;
    assign THIGHs_o  = thigh_q;
    assign ALERT_o   = alert_q;
    assign BUSY_o    = (state_q == S_ADR_ACK) || (state_q == S_WT_DAT) || (state_q == S_WT_ACK) ||
                       (state_q == S_RD_DAT)  || (state_q == S_RD_ACK);

endmodule

// File: tb/tb_s5851a_i2c_slv.sv
// Bench for s5851a_i2c_slv: bit-banged I2C master, register/ALERT model,
// directed sequences, an ALERT vector table and randomized transactions.
module tb_s5851a_i2c_slv;
    localparam int         HP  = 8;
    localparam logic [6:0] ADR = 7'h48;

    logic        CK    = 1'b0;
    logic        SRST  = 1'b1;
    logic        scl_m = 1'b1;
    logic        sda_m = 1'b1;
    logic [11:0] temp  = 12'h000;
    logic        sdao, sdai, alert, busy;
    logic [7:0]  cfg;
    logic [15:0] tlow, thigh;

    assign sdai = sda_m & sdao;

    s5851a_i2c_slv dut (
        .CK_i(CK), .SRST_i(SRST), .SCLI_i(scl_m), .SDAI_i(sdai), .SDAO_o(sdao),
        .TEMPs_i(temp), .CONFIGs_o(cfg), .TLOWs_o(tlow), .THIGHs_o(thigh),
        .ALERT_o(alert), .BUSY_o(busy)
    );

    always #5 CK = ~CK;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    // reference model of the target's register file
    logic [1:0]  m_ptr   = 2'd0;
    logic [7:0]  m_cfg   = 8'h00;
    logic [15:0] m_tlow  = 16'h4B00;
    logic [15:0] m_thigh = 16'h5000;
    logic        m_alert = 1'b0;
    logic [7:0]  wbuf [4];
    logic [7:0]  rbuf [4];

    function automatic int s12(input logic [11:0] v);
        return (v >= 12'h800) ? int'(v) - 4096 : int'(v);
    endfunction

    task automatic mdl_write(input int n);
        if (n >= 1) m_ptr = wbuf[0][1:0];
        for (int k = 1; k < n; k++) begin
            if (m_ptr == 2'd1) m_cfg = wbuf[k];
            if (k == 2 && m_ptr == 2'd2) m_tlow  = {wbuf[1], wbuf[2]};
            if (k == 2 && m_ptr == 2'd3) m_thigh = {wbuf[1], wbuf[2]};
        end
    endtask

    function automatic logic [7:0] mdl_rd(input int k, input logic [11:0] t);
        logic [15:0] v;
        if (m_ptr == 2'd1) return m_cfg;
        v = (m_ptr == 2'd0) ? {t, 4'h0} : (m_ptr == 2'd2) ? m_tlow : m_thigh;
        if (k == 0) return v[15:8];
        if (k == 1) return v[7:0];
        return 8'hFF;
    endfunction

    task automatic mdl_alert(input logic [11:0] t);
        if (s12(t) > s12(m_thigh[15:4]))     m_alert = 1'b1;
        else if (s12(t) < s12(m_tlow[15:4])) m_alert = 1'b0;
    endtask

    logic busy_watch = 1'b0;
    logic busy_seen  = 1'b0;
    always @(negedge CK) if (busy_watch && busy) busy_seen = 1'b1;

    initial begin
        #900000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1);
    end

    task automatic wck(input int n);
        repeat (n) @(negedge CK);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wck(HP);
        scl_m = 1'b1; wck(HP);
        sda_m = 1'b0; wck(HP);
        scl_m = 1'b0; wck(HP);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wck(HP);
        scl_m = 1'b1; wck(HP);
        sda_m = 1'b1; wck(HP);
    endtask

    task automatic wr_bit(input logic b);
        sda_m = b;    wck(HP);
        scl_m = 1'b1; wck(HP);
        scl_m = 1'b0; wck(2);
    endtask

    task automatic rd_bit(output logic b);
        sda_m = 1'b1; wck(HP);
        scl_m = 1'b1; wck(HP / 2);
        b = sdai;     wck(HP / 2);
        scl_m = 1'b0; wck(2);
    endtask

    task automatic tx_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) wr_bit(b[i]);
        rd_bit(ack);
    endtask

    task automatic rx_byte(output logic [7:0] b, input logic nack);
        logic v;
        b = '0;
        for (int i = 7; i >= 0; i--) begin
            rd_bit(v);
            b[i] = v;
        end
        wr_bit(nack);
    endtask

    // START, address(W), n bytes from wbuf; every ACK must be low; no STOP
    task automatic do_write(input int n);
        logic a;
        i2c_start();
        tx_byte({ADR, 1'b0}, a);
        chk("wr_adr_ack", a, 1'b0);
        for (int i = 0; i < n; i++) begin
            tx_byte(wbuf[i], a);
            chk($sformatf("wr_dat_ack%0d", i), a, 1'b0);
        end
    endtask

    // START, address(R), n bytes into rbuf checked against the model; no STOP
    task automatic do_read(input int n, input bit chg, input logic [11:0] new_t);
        logic a;
        logic [11:0] snap;
        i2c_start();
        tx_byte({ADR, 1'b1}, a);
        chk("rd_adr_ack", a, 1'b0);
        snap = temp;
        for (int i = 0; i < n; i++) begin
            if (i == 1 && chg) temp = new_t;
            rx_byte(rbuf[i], (i == n - 1));
            chk($sformatf("rd_byte%0d_p%0d", i, m_ptr), rbuf[i], mdl_rd(i, snap));
        end
    endtask

    task automatic chk_regs(input string nm);
        chk({nm, "_cfg"},   cfg,   m_cfg);
        chk({nm, "_tlow"},  tlow,  m_tlow);
        chk({nm, "_thigh"}, thigh, m_thigh);
    endtask

    typedef struct {
        logic [11:0] t;
        logic        a;
    } alert_vec_t;

    alert_vec_t avec [10];

    initial begin
        logic       a, b;
        logic [7:0] by;
        int         n, kind;

        avec[0] = '{12'h000, 1'b0};
        avec[1] = '{12'h150, 1'b0};
        avec[2] = '{12'h190, 1'b0};
        avec[3] = '{12'h191, 1'b1};
        avec[4] = '{12'h160, 1'b1};
        avec[5] = '{12'h140, 1'b1};
        avec[6] = '{12'h13F, 1'b0};
        avec[7] = '{12'hF00, 1'b0};
        avec[8] = '{12'h7FF, 1'b1};
        avec[9] = '{12'h800, 1'b0};

        // reset state
        SRST = 1'b1;
        wck(3);
        chk("rst_sdao",  sdao,  1'b1);
        chk("rst_cfg",   cfg,   8'h00);
        chk("rst_tlow",  tlow,  16'h4B00);
        chk("rst_thigh", thigh, 16'h5000);
        chk("rst_alert", alert, 1'b0);
        chk("rst_busy",  busy,  1'b0);
        SRST = 1'b0;
        wck(4);

        // pointer 2, TLOW <= 1E00, then read it back
        wbuf = '{8'h02, 8'h1E, 8'h00, 8'h00};
        do_write(3);
        chk("busy_wr", busy, 1'b1);
        i2c_stop();
        mdl_write(3);
        chk("tlow_1e00", tlow, 16'h1E00);
        do_read(2, 1'b0, 12'h000);
        chk("tlow_rd_msb", rbuf[0], 8'h1E);
        chk("tlow_rd_lsb", rbuf[1], 8'h00);
        i2c_stop();

        // temperature read, TEMP changes between bytes
        temp = 12'h191;
        wbuf[0] = 8'h00;
        do_write(1);
        mdl_write(1);
        do_read(2, 1'b1, 12'h200);
        chk("temp_msb", rbuf[0], 8'h19);
        chk("temp_lsb_snap", rbuf[1], 8'h10);
        i2c_stop();

        // foreign address: no ACK, never busy, no register change
        busy_seen  = 1'b0;
        busy_watch = 1'b1;
        i2c_start();
        tx_byte({7'h3E, 1'b0}, a);
        chk("foreign_adr_nack", a, 1'b1);
        tx_byte(8'h01, a);
        chk("foreign_ptr_nack", a, 1'b1);
        tx_byte(8'h55, a);
        chk("foreign_dat_nack", a, 1'b1);
        busy_watch = 1'b0;
        chk("foreign_busy", busy_seen, 1'b0);
        i2c_stop();
        chk_regs("foreign");

        // CONFIG write, 3-byte read, then a master NACK
        wbuf = '{8'h01, 8'h60, 8'h00, 8'h00};
        do_write(2);
        i2c_stop();
        mdl_write(2);
        chk("cfg_60", cfg, 8'h60);
        do_read(3, 1'b0, 12'h000);
        chk("cfg_rd2", rbuf[2], 8'h60);
        i2c_stop();
        i2c_start();
        tx_byte({ADR, 1'b1}, a);
        rx_byte(by, 1'b1);
        chk("nack_byte", by, 8'h60);
        rx_byte(by, 1'b1);
        chk("ignore_released", by, 8'hFF);
        chk("ignore_busy", busy, 1'b0);
        i2c_stop();

        // ALERT hysteresis table with THIGH=1900, TLOW=1400
        temp = 12'h000;
        wbuf = '{8'h03, 8'h19, 8'h00, 8'h00};
        do_write(3); i2c_stop(); mdl_write(3);
        wbuf = '{8'h02, 8'h14, 8'h00, 8'h00};
        do_write(3); i2c_stop(); mdl_write(3);
        chk_regs("alert_thr");
        for (int i = 0; i < 10; i++) begin
            temp = avec[i].t;
            wck(2);
            chk($sformatf("alert_tbl%0d_%03h", i, avec[i].t), alert, avec[i].a);
        end

        // reset during the 4th data bit of a CONFIG read
        wbuf[0] = 8'h01;
        do_write(1);
        mdl_write(1);
        i2c_start();
        tx_byte({ADR, 1'b1}, a);
        chk("rst_seq_ack", a, 1'b0);
        rd_bit(b); chk("rst_seq_b7", b, 1'b0);
        rd_bit(b); chk("rst_seq_b6", b, 1'b1);
        rd_bit(b); chk("rst_seq_b5", b, 1'b1);
        sda_m = 1'b1; wck(HP);
        scl_m = 1'b1; wck(HP / 2);
        chk("rst_seq_b4_drv", sdao, 1'b0);
        SRST = 1'b1;
        wck(1);
        chk("mid_rst_sdao", sdao, 1'b1);
        SRST = 1'b0;
        m_cfg = 8'h00; m_tlow = 16'h4B00; m_thigh = 16'h5000; m_ptr = 2'd0;
        chk_regs("mid_rst");
        chk("mid_rst_busy", busy, 1'b0);
        wck(HP / 2);
        scl_m = 1'b0;
        wck(HP);
        wbuf = '{8'h02, 8'h1E, 8'h00, 8'h00};
        do_write(3); i2c_stop(); mdl_write(3);
        chk("post_rst_tlow", tlow, 16'h1E00);
        do_read(2, 1'b0, 12'h000);
        i2c_stop();

        // randomized transactions against the model
        for (int it = 0; it < 16; it++) begin
            kind = $urandom_range(0, 2);
            if (kind == 0) begin
                n = $urandom_range(1, 4);
                for (int k = 0; k < 4; k++) wbuf[k] = 8'($urandom);
                do_write(n);
                i2c_stop();
                mdl_write(n);
                chk_regs($sformatf("rnd%0d_wr", it));
            end else if (kind == 1) begin
                temp = 12'($urandom);
                n = $urandom_range(1, 4);
                if ($urandom_range(0, 1) == 1) begin
                    wbuf[0] = 8'($urandom);
                    do_write(1);
                    mdl_write(1);
                end
                do_read(n, 1'($urandom_range(0, 1)), 12'($urandom));
                i2c_stop();
            end else begin
                by = 8'($urandom);
                if (by[7:1] == ADR) by[7] = ~by[7];
                i2c_start();
                tx_byte(by, a);
                chk($sformatf("rnd%0d_foreign", it), a, 1'b1);
                tx_byte(8'($urandom), a);
                i2c_stop();
                chk_regs($sformatf("rnd%0d_foreign", it));
            end
        end

        // randomized ALERT sweep, THIGH=3200 (50 C), TLOW=2800 (40 C)
        temp = 12'h000;
        wbuf = '{8'h03, 8'h32, 8'h00, 8'h00};
        do_write(3); i2c_stop(); mdl_write(3);
        wbuf = '{8'h02, 8'h28, 8'h00, 8'h00};
        do_write(3); i2c_stop(); mdl_write(3);
        m_alert = 1'b0;
        wck(2);
        chk("rnd_alert_init", alert, m_alert);
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) temp = 12'($urandom);
            else temp = 12'(32'h280 + $urandom_range(0, 256));
            mdl_alert(temp);
            wck(2);
            chk($sformatf("rnd_alert%0d_%03h", i, temp), alert, m_alert);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
